cavlc_bitstream_packer: RTL and testbench

Consumer end of the CAVLC encoder output interface. It accepts variable-length codes of 0..127 bits, one per handshake, and concatenates them MSB-first into a continuous bitstream. It emits the stream as 32-bit words over a valid/ready output to the downstream memory writer. On request it flushes the residual bits, with an optional rbsp stop bit and zero padding, so the slice ends byte/word aligned.

---
 rtl/cavlc_bitstream_packer.sv | 99 +++++++++
 tb/tb_cavlc_bitstream_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_bitstream_packer.sv
// cavlc_bitstream_packer: concatenates variable-length CAVLC codes MSB-first into 32-bit words,
// with an end-of-slice flush that optionally appends the rbsp stop bit and zero-pads the tail.
module cavlc_bitstream_packer #(
    parameter logic STOP_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cavlc_enc_valid,
    input  logic [127:0] cavlc_bitstream_code,
    input  logic [6:0]   cavlc_bitstream_bit,
    output logic         packer_ready,
    input  logic         flush,
    output logic         flush_done,
    output logic [31:0]  out_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [5:0]   fill_level,
    output logic [31:0]  bits_total
);
    typedef enum logic [1:0] {IDLE, DRAIN, PAD, LAST} state_t;

    state_t         state;
    logic [159:0]   sbuf;
    logic [7:0]     fill;
    logic           flush_pending;
    logic           done_q;
    logic           accept;
    logic [127:0]   mask;
    logic [7:0]     new_fill;
    logic [7:0]     pad_fill;

    assign packer_ready = (state == IDLE) && !flush_pending && !rst;
    assign accept       = cavlc_enc_valid && packer_ready;
    assign mask         = (128'd1 << cavlc_bitstream_bit) - 128'd1;
    assign new_fill     = fill + {1'b0, cavlc_bitstream_bit};
    assign pad_fill     = fill + {7'd0, STOP_BIT};
    assign out_valid    = (state == DRAIN) || (state == LAST);
    assign out_last     = (state == LAST);
    assign fill_level   = fill[5:0];
    assign flush_done   = done_q || ((state == LAST) && out_ready);
    // Oldest bit sits at sbuf[fill-1]; the tail word is left-justified so padding falls in the LSBs.
    assign out_word     = !out_valid ? 32'd0 :
                          (fill >= 8'd32) ? 32'(sbuf >> (fill - 8'd32)) : 32'(sbuf << (8'd32 - fill));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sbuf          <= '0;
            fill          <= '0;
            flush_pending <= 1'b0;
            done_q        <= 1'b0;
            bits_total    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sbuf       <= (sbuf << cavlc_bitstream_bit) | {32'd0, cavlc_bitstream_code & mask};
                        fill       <= new_fill;
                        bits_total <= bits_total + 32'(cavlc_bitstream_bit);
                    end
                    if (flush) flush_pending <= 1'b1;
                    if (accept && new_fill >= 8'd32) state <= DRAIN;
                    else if (flush || flush_pending) state <= PAD;
                end
                DRAIN: begin
                    if (flush) flush_pending <= 1'b1;
                    if (out_ready) begin
                        fill <= fill - 8'd32;
                        if (fill < 8'd64) state <= (flush_pending || flush) ? PAD : IDLE;
                    end
                end
                PAD: begin
                    if (STOP_BIT) begin
                        sbuf       <= {sbuf[158:0], 1'b1};
                        fill       <= pad_fill;
                        bits_total <= bits_total + 32'd1;
                    end
                    if (pad_fill == 8'd0) begin
                        done_q        <= 1'b1;
                        flush_pending <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    if (out_ready) begin
                        fill          <= '0;
                        flush_pending <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cavlc_bitstream_packer.sv
// tb_cavlc_bitstream_packer: directed checks of the packer with and without the rbsp stop bit.
module tb_cavlc_bitstream_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cavlc_enc_valid = 1'b0;
    logic [127:0] code = '0;
    logic [6:0]   len = '0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b1;
    logic         ready0, ready1, done0, done1, valid0, valid1, last0, last1;
    logic [31:0]  word0, word1, total0, total1;
    logic [5:0]   level0, level1;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    cavlc_bitstream_packer #(.STOP_BIT(1'b0)) u0 (
        .clk(clk), .rst(rst), .cavlc_enc_valid(cavlc_enc_valid), .cavlc_bitstream_code(code),
        .cavlc_bitstream_bit(len), .packer_ready(ready0), .flush(flush), .flush_done(done0),
        .out_word(word0), .out_valid(valid0), .out_ready(out_ready), .out_last(last0),
        .fill_level(level0), .bits_total(total0));

    cavlc_bitstream_packer #(.STOP_BIT(1'b1)) u1 (
        .clk(clk), .rst(rst), .cavlc_enc_valid(cavlc_enc_valid), .cavlc_bitstream_code(code),
        .cavlc_bitstream_bit(len), .packer_ready(ready1), .flush(flush), .flush_done(done1),
        .out_word(word1), .out_valid(valid1), .out_ready(out_ready), .out_last(last1),
        .fill_level(level1), .bits_total(total1));

    typedef struct {
        logic [6:0]   len;
        logic [127:0] code;
        logic         same;
        logic [31:0]  exp0;
        logic [31:0]  exp1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cavlc_enc_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; len = '0; code = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid0();
        for (int i = 0; i < 8; i++) begin
            if (valid0) return;
            @(negedge clk);
        end
        chk("wait_valid_timeout", 32'(valid0), 32'd1);
    endtask

    initial begin
        vecs[0] = '{7'd1,  128'h1,          1'b0, 32'h8000_0000, 32'hC000_0000};
        vecs[1] = '{7'd4,  128'hA,          1'b0, 32'hA000_0000, 32'hA800_0000};
        vecs[2] = '{7'd8,  128'h1A5,        1'b0, 32'hA500_0000, 32'hA580_0000};
        vecs[3] = '{7'd31, 128'h1234_5678,  1'b0, 32'h2468_ACF0, 32'h2468_ACF1};
        vecs[4] = '{7'd16, 128'hFFFF_0000,  1'b0, 32'h0000_0000, 32'h0000_8000};
        vecs[5] = '{7'd4,  128'hA,          1'b1, 32'hA000_0000, 32'hA800_0000};

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_word", word0, 32'd0);
        chk("rst_last", 32'(last0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_level", 32'(level0), 32'd0);
        chk("rst_total", total0, 32'd0);
        rst = 1'b0;

        // Two codes completing one word
        do_reset();
        cavlc_enc_valid = 1'b1; len = 7'd3; code = 128'h5;
        @(negedge clk);
        chk("two_ready", 32'(ready0), 32'd1);
        len = 7'd29; code = 128'h1FFF_FFFF;
        @(negedge clk);
        cavlc_enc_valid = 1'b0;
        chk("two_valid", 32'(valid0), 32'd1);
        chk("two_word", word0, 32'hBFFF_FFFF);
        chk("two_last", 32'(last0), 32'd0);
        @(negedge clk);
        chk("two_valid_after", 32'(valid0), 32'd0);
        chk("two_level", 32'(level0), 32'd0);
        chk("two_total", total0, 32'd32);

        // 127 ones, then flush of the 31-bit remainder
        do_reset();
        cavlc_enc_valid = 1'b1; len = 7'd127; code = {128{1'b1}};
        @(negedge clk);
        cavlc_enc_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            chk("ones_ready", 32'(ready0), 32'd0);
            chk("ones_valid", 32'(valid0), 32'd1);
            chk("ones_word", word0, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        chk("ones_idle_valid", 32'(valid0), 32'd0);
        chk("ones_level", 32'(level0), 32'd31);
        chk("ones_idle_ready", 32'(ready0), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid0();
        chk("ones_tail0", word0, 32'hFFFF_FFFE);
        chk("ones_last0", 32'(last0), 32'd1);
        chk("ones_done0", 32'(done0), 32'd1);
        chk("ones_tail1", word1, 32'hFFFF_FFFF);
        chk("ones_last1", 32'(last1), 32'd1);
        chk("ones_total1", total1, 32'd128);
        @(negedge clk);
        chk("ones_done_clear", 32'(done0), 32'd0);

        // Backpressure: words must stay stable and no code is taken while stalled
        do_reset();
        begin
            logic [127:0] pat;
            pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
            cavlc_enc_valid = 1'b1; len = 7'd127; code = pat; out_ready = 1'b0;
            @(negedge clk);
            len = 7'd5; code = 128'h1F;
            for (int w = 0; w < 3; w++) begin
                for (int k = 0; k < 5; k++) begin
                    if (k == 0) out_ready = 1'b0;
                    chk("stall_valid", 32'(valid0), 32'd1);
                    chk("stall_word", word0, pat[126 - 32*w -: 32]);
                    chk("stall_ready", 32'(ready0), 32'd0);
                    if (k == 4) begin
                        out_ready = 1'b1;
                        if (w == 2) cavlc_enc_valid = 1'b0;
                    end
                    @(negedge clk);
                end
            end
            chk("stall_idle_valid", 32'(valid0), 32'd0);
            chk("stall_level", 32'(level0), 32'd31);
            chk("stall_total", total0, 32'd127);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            wait_valid0();
            chk("stall_tail0", word0, {pat[30:0], 1'b0});
            chk("stall_tail1", word1, {pat[30:0], 1'b1});
        end

        // Flush with nothing buffered
        do_reset();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("empty_done_early", 32'(done0), 32'd0);
        @(negedge clk);
        chk("empty_done0", 32'(done0), 32'd1);
        chk("empty_valid0", 32'(valid0), 32'd0);
        chk("empty_valid1", 32'(valid1), 32'd1);
        chk("empty_word1", word1, 32'h8000_0000);
        chk("empty_last1", 32'(last1), 32'd1);
        chk("empty_done1", 32'(done1), 32'd1);
        chk("empty_total1", total1, 32'd1);
        @(negedge clk);
        chk("empty_done0_clear", 32'(done0), 32'd0);
        chk("empty_total0", total0, 32'd0);

        // Single short code then flush, from the table
        for (int v = 0; v < 6; v++) begin
            do_reset();
            cavlc_enc_valid = 1'b1; len = vecs[v].len; code = vecs[v].code; flush = vecs[v].same;
            @(negedge clk);
            cavlc_enc_valid = 1'b0; flush = !vecs[v].same;
            @(negedge clk);
            flush = 1'b0;
            wait_valid0();
            chk($sformatf("vec%0d_word0", v), word0, vecs[v].exp0);
            chk($sformatf("vec%0d_last0", v), 32'(last0), 32'd1);
            chk($sformatf("vec%0d_done0", v), 32'(done0), 32'd1);
            chk($sformatf("vec%0d_word1", v), word1, vecs[v].exp1);
            chk($sformatf("vec%0d_last1", v), 32'(last1), 32'd1);
            chk($sformatf("vec%0d_total0", v), total0, 32'(vecs[v].len));
            chk($sformatf("vec%0d_total1", v), total1, 32'(vecs[v].len) + 32'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_idle_valid", v), 32'(valid0), 32'd0);
            chk($sformatf("vec%0d_idle_level", v), 32'(level0), 32'd0);
            chk($sformatf("vec%0d_idle_ready", v), 32'(ready0), 32'd1);
        end

        // Reset while a word is waiting
        do_reset();
        cavlc_enc_valid = 1'b1; len = 7'd40; code = 128'hFF_0000_0001; out_ready = 1'b0;
        @(negedge clk);
        cavlc_enc_valid = 1'b0;
        chk("rstmid_word", word0, 32'hFF00_0000);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", 32'(valid0), 32'd0);
        chk("rstmid_level", 32'(level0), 32'd0);
        chk("rstmid_total", total0, 32'd0);
        chk("rstmid_ready_in_rst", 32'(ready0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(ready0), 32'd1);
        chk("rstmid_valid_after", 32'(valid0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
